// File: rtl/issue_if.sv
// Decode-to-issue bundle: decoded pair attributes in, issue decisions out.
// master drives the decoded pair and the pipeline controls; slave is the scheduler.
interface issue_if;
    logic       pipe_stall;
    logic       flush;
    logic       m_valid,   s_valid;
    logic [4:0] m_rs,      m_rt,      s_rs,      s_rt;
    logic       m_rs_used, m_rt_used, s_rs_used, s_rt_used;
    logic [4:0] m_dest,    s_dest;
    logic       m_reg_en,  s_reg_en;
    logic       m_load,    s_load;
    logic       m_mem,     s_mem;
    logic       m_muldiv,  s_muldiv;
    logic       s_branch;
    logic       master_issue;
    logic       slave_issue;
    logic       decode_stall;
    logic       muldiv_start;
    logic       muldiv_busy;

    modport master (
        output pipe_stall, flush, m_valid, s_valid,
               m_rs, m_rt, s_rs, s_rt, m_rs_used, m_rt_used, s_rs_used, s_rt_used,
               m_dest, s_dest, m_reg_en, s_reg_en, m_load, s_load,
               m_mem, s_mem, m_muldiv, s_muldiv, s_branch,
        input  master_issue, slave_issue, decode_stall, muldiv_start, muldiv_busy
    );

    modport slave (
        input  pipe_stall, flush, m_valid, s_valid,
               m_rs, m_rt, s_rs, s_rt, m_rs_used, m_rt_used, s_rs_used, s_rt_used,
               m_dest, s_dest, m_reg_en, s_reg_en, m_load, s_load,
               m_mem, s_mem, m_muldiv, s_muldiv, s_branch,
        output master_issue, slave_issue, decode_stall, muldiv_start, muldiv_busy
    );
endinterface

// File: rtl/issue_ctrl.sv
// Dual-issue scheduler: load-use shadow, intra-pair hazards, mul/div busy block.
// Zero-cycle issue decision; holds the pair on pipe_stall, drops it on flush.
module issue_ctrl #(
    parameter int unsigned MULDIV_CYCLES = 8
) (
    input  logic    clk,
    input  logic    rst,
    issue_if.slave  bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [4:0] CNT_INIT = 5'(MULDIV_CYCLES - 1);

    state_t     state_q;
    logic [4:0] cnt_q;
    logic       sh_m_vld_q, sh_s_vld_q, sh_m_vld_d, sh_s_vld_d;
    logic [4:0] sh_m_addr_q, sh_s_addr_q, sh_m_addr_d, sh_s_addr_d;

    function automatic logic load_hit(input logic [4:0] x,
                                      input logic mv, input logic [4:0] ma,
                                      input logic sv, input logic [4:0] sa);
        return (x != 5'd0) && ((mv && ma == x) || (sv && sa == x));
    endfunction

    logic m_src_hit, s_src_hit, raw_hit, waw_hit, m_ok, s_ok;

    assign m_src_hit = (bus.m_rs_used && load_hit(bus.m_rs, sh_m_vld_q, sh_m_addr_q, sh_s_vld_q, sh_s_addr_q))
                    || (bus.m_rt_used && load_hit(bus.m_rt, sh_m_vld_q, sh_m_addr_q, sh_s_vld_q, sh_s_addr_q));
    assign s_src_hit = (bus.s_rs_used && load_hit(bus.s_rs, sh_m_vld_q, sh_m_addr_q, sh_s_vld_q, sh_s_addr_q))
                    || (bus.s_rt_used && load_hit(bus.s_rt, sh_m_vld_q, sh_m_addr_q, sh_s_vld_q, sh_s_addr_q));
    assign raw_hit   = bus.m_reg_en && (bus.m_dest != 5'd0)
                    && ((bus.s_rs_used && bus.s_rs == bus.m_dest) || (bus.s_rt_used && bus.s_rt == bus.m_dest));
    assign waw_hit   = bus.m_reg_en && bus.s_reg_en && (bus.m_dest == bus.s_dest) && (bus.m_dest != 5'd0);

    assign m_ok = !rst && bus.m_valid && !bus.pipe_stall && !bus.flush
               && (state_q == IDLE) && !m_src_hit;
    assign s_ok = m_ok && bus.s_valid && !bus.s_branch && !bus.s_muldiv
               && !(bus.m_mem && bus.s_mem) && !s_src_hit && !raw_hit && !waw_hit;

    assign bus.master_issue = m_ok;
    assign bus.slave_issue  = s_ok;
    assign bus.decode_stall = !rst && bus.m_valid && !m_ok;
    assign bus.muldiv_start = m_ok && bus.m_muldiv;
    assign bus.muldiv_busy  = (state_q == BUSY);

    // The shadow follows the pair into EX; a held slot advances as a bubble.
    always_comb begin
        sh_m_vld_d  = sh_m_vld_q;
        sh_m_addr_d = sh_m_addr_q;
        sh_s_vld_d  = sh_s_vld_q;
        sh_s_addr_d = sh_s_addr_q;
        if (bus.flush) begin
            sh_m_vld_d = 1'b0;
            sh_s_vld_d = 1'b0;
        end else if (!bus.pipe_stall) begin
            sh_m_vld_d  = m_ok && bus.m_load && bus.m_reg_en && (bus.m_dest != 5'd0);
            sh_m_addr_d = bus.m_dest;
            sh_s_vld_d  = s_ok && bus.s_load && bus.s_reg_en && (bus.s_dest != 5'd0);
            sh_s_addr_d = bus.s_dest;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_m_vld_q  <= 1'b0;
            sh_m_addr_q <= 5'd0;
            sh_s_vld_q  <= 1'b0;
            sh_s_addr_q <= 5'd0;
        end else begin
            sh_m_vld_q  <= sh_m_vld_d;
            sh_m_addr_q <= sh_m_addr_d;
            sh_s_vld_q  <= sh_s_vld_d;
            sh_s_addr_q <= sh_s_addr_d;
        end
    end

    // Counter keeps running under pipe_stall: the unit finishes regardless.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
        end else begin
            case (state_q)
                IDLE: if (m_ok && bus.m_muldiv) begin
                    state_q <= BUSY;
                    cnt_q   <= CNT_INIT;
                end
                BUSY: if (cnt_q == 5'd0) begin
                    state_q <= IDLE;
                end else begin
                    cnt_q <= cnt_q - 5'd1;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 5'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_issue_ctrl.sv
// Directed test-plan scenarios followed by randomized traffic, compared against a cycle model.
module tb_issue_ctrl;
    localparam int MDC = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    issue_if bus ();
    issue_ctrl #(.MULDIV_CYCLES(MDC)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Model state: destination of each load issued last cycle (0 = none), blocked cycles left.
    int sh_dest [2];
    int busy_left;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    function automatic logic hit(input logic [4:0] x);
        return (x != 0) && (int'(x) == sh_dest[0] || int'(x) == sh_dest[1]);
    endfunction

    task automatic model_eval(output logic mi, output logic si, output logic ds,
                              output logic st, output logic bz);
        logic s_reads_mdest;
        bz = busy_left > 0;
        mi = !rst && bus.m_valid && !bus.pipe_stall && !bus.flush && !bz
             && !(bus.m_rs_used && hit(bus.m_rs)) && !(bus.m_rt_used && hit(bus.m_rt));
        s_reads_mdest = (bus.s_rs_used && bus.s_rs == bus.m_dest) || (bus.s_rt_used && bus.s_rt == bus.m_dest);
        si = mi && bus.s_valid && !bus.s_branch && !bus.s_muldiv && !(bus.m_mem && bus.s_mem)
             && !(bus.s_rs_used && hit(bus.s_rs)) && !(bus.s_rt_used && hit(bus.s_rt))
             && !(bus.m_reg_en && bus.m_dest != 0 && s_reads_mdest)
             && !(bus.m_reg_en && bus.s_reg_en && bus.m_dest == bus.s_dest && bus.m_dest != 0);
        ds = !rst && bus.m_valid && !mi;
        st = mi && bus.m_muldiv;
    endtask

    task automatic model_update(input logic mi, input logic si);
        if (rst || bus.flush) begin
            busy_left = 0;
            sh_dest[0] = 0;
            sh_dest[1] = 0;
        end else begin
            if (busy_left > 0) busy_left--;
            else if (mi && bus.m_muldiv) busy_left = MDC;
            if (!bus.pipe_stall) begin
                sh_dest[0] = (mi && bus.m_load && bus.m_reg_en) ? int'(bus.m_dest) : 0;
                sh_dest[1] = (si && bus.s_load && bus.s_reg_en) ? int'(bus.s_dest) : 0;
            end
        end
    endtask

    // One clock: compare at the mid-cycle point, then advance the model at the edge.
    // e_mi/e_si/e_bz: -1 = no directed expectation.
    task automatic step(input int e_mi, input int e_si, input int e_bz);
        logic mi, si, ds, st, bz;
        #1;
        model_eval(mi, si, ds, st, bz);
        chk("master_issue", bus.master_issue, mi);
        chk("slave_issue", bus.slave_issue, si);
        chk("decode_stall", bus.decode_stall, ds);
        chk("muldiv_start", bus.muldiv_start, st);
        chk("muldiv_busy", bus.muldiv_busy, bz);
        if (e_mi >= 0) chk("dir_master_issue", bus.master_issue, e_mi[0]);
        if (e_si >= 0) chk("dir_slave_issue", bus.slave_issue, e_si[0]);
        if (e_bz >= 0) chk("dir_muldiv_busy", bus.muldiv_busy, e_bz[0]);
        @(posedge clk);
        model_update(mi, si);
        @(negedge clk);
    endtask

    task automatic nop();
        bus.pipe_stall = 0; bus.flush = 0; bus.m_valid = 0; bus.s_valid = 0;
        bus.m_rs = 0; bus.m_rt = 0; bus.s_rs = 0; bus.s_rt = 0;
        bus.m_rs_used = 0; bus.m_rt_used = 0; bus.s_rs_used = 0; bus.s_rt_used = 0;
        bus.m_dest = 0; bus.s_dest = 0; bus.m_reg_en = 0; bus.s_reg_en = 0;
        bus.m_load = 0; bus.s_load = 0; bus.m_mem = 0; bus.s_mem = 0;
        bus.m_muldiv = 0; bus.s_muldiv = 0; bus.s_branch = 0;
    endtask

    task automatic set_m(input int dest, input int rs, input int rt, input logic ld, input logic md);
        bus.m_valid = 1; bus.m_dest = 5'(dest); bus.m_reg_en = (dest != 0) || ld;
        bus.m_rs = 5'(rs); bus.m_rs_used = 1; bus.m_rt = 5'(rt); bus.m_rt_used = 1;
        bus.m_load = ld; bus.m_mem = ld; bus.m_muldiv = md;
    endtask

    task automatic set_s(input int dest, input int rs, input int rt);
        bus.s_valid = 1; bus.s_dest = 5'(dest); bus.s_reg_en = 1;
        bus.s_rs = 5'(rs); bus.s_rs_used = 1; bus.s_rt = 5'(rt); bus.s_rt_used = 1;
        bus.s_load = 0; bus.s_mem = 0; bus.s_muldiv = 0; bus.s_branch = 0;
    endtask

    task automatic rand_inputs();
        bus.pipe_stall = ($urandom_range(0, 9) == 0);
        bus.flush      = ($urandom_range(0, 29) == 0);
        bus.m_valid = ($urandom_range(0, 7) != 0); bus.s_valid = $urandom_range(0, 1) != 0;
        bus.m_rs = 5'($urandom_range(0, 7)); bus.m_rt = 5'($urandom_range(0, 7));
        bus.s_rs = 5'($urandom_range(0, 7)); bus.s_rt = 5'($urandom_range(0, 7));
        bus.m_dest = 5'($urandom_range(0, 7)); bus.s_dest = 5'($urandom_range(0, 7));
        bus.m_rs_used = $urandom_range(0, 1) != 0; bus.m_rt_used = $urandom_range(0, 1) != 0;
        bus.s_rs_used = $urandom_range(0, 1) != 0; bus.s_rt_used = $urandom_range(0, 1) != 0;
        bus.m_reg_en = $urandom_range(0, 3) != 0; bus.s_reg_en = $urandom_range(0, 3) != 0;
        bus.m_mem = $urandom_range(0, 2) == 0; bus.s_mem = $urandom_range(0, 2) == 0;
        bus.m_load = bus.m_mem && ($urandom_range(0, 1) != 0);
        bus.s_load = bus.s_mem && ($urandom_range(0, 1) != 0);
        bus.m_muldiv = $urandom_range(0, 15) == 0; bus.s_muldiv = $urandom_range(0, 15) == 0;
        bus.s_branch = $urandom_range(0, 7) == 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        sh_dest[0] = 0; sh_dest[1] = 0; busy_left = 0;
        nop();
        rst = 1;
        @(negedge clk);
        // m_valid is ignored while reset is held.
        set_m(3, 1, 2, 0, 0);
        step(0, 0, -1);
        step(0, 0, 0);
        rst = 0;

        // Independent pair issues together every cycle.
        set_m(3, 1, 2, 0, 0); set_s(5, 6, 7);
        repeat (3) step(1, 1, 0);

        // Load-use: one bubble, then issue.
        nop(); set_m(8, 1, 0, 1, 0); step(1, -1, -1);
        set_m(9, 8, 1, 0, 0); step(0, -1, -1);
        step(1, -1, -1);
        // Load to $0 never creates a hazard.
        set_m(0, 1, 0, 1, 0); bus.m_reg_en = 1; step(1, -1, -1);
        set_m(9, 0, 0, 0, 0); step(1, -1, -1);

        // Intra-pair RAW, two memory ops, slave branch, WAW.
        nop(); set_m(4, 1, 2, 0, 0); set_s(6, 4, 2); step(1, 0, -1);
        set_m(4, 1, 2, 1, 0); set_s(6, 1, 2); bus.s_mem = 1; step(1, 0, -1);
        set_m(4, 1, 2, 0, 0); set_s(6, 1, 2); bus.s_branch = 1; step(1, 0, -1);
        set_m(4, 1, 2, 0, 0); set_s(4, 1, 2); step(1, 0, -1);

        // Mul/div blocks T+1..T+8, issue resumes at T+9.
        nop(); set_m(0, 1, 2, 0, 1); step(1, 0, 0);
        set_m(3, 1, 2, 0, 0);
        repeat (MDC) step(0, 0, 1);
        step(1, -1, 0);

        // Stall after a load holds the shadow, so one bubble remains after release.
        nop(); set_m(8, 1, 0, 1, 0); step(1, -1, -1);
        set_m(9, 8, 1, 0, 0); bus.pipe_stall = 1;
        repeat (3) step(0, 0, -1);
        bus.pipe_stall = 0; step(0, -1, -1);
        step(1, -1, -1);

        // Flush while busy with cnt=4.
        nop(); set_m(0, 1, 2, 0, 1); step(1, 0, 0);
        set_m(3, 1, 2, 0, 0);
        repeat (3) step(0, -1, 1);
        bus.flush = 1; step(0, 0, 1);
        bus.flush = 0; step(1, -1, 0);
        // Flush clears the load shadow.
        set_m(8, 1, 0, 1, 0); step(1, -1, -1);
        set_m(9, 8, 1, 0, 0); bus.flush = 1; step(0, 0, -1);
        bus.flush = 0; step(1, -1, -1);
        // Flush beats a mul/div request.
        set_m(0, 1, 2, 0, 1); bus.flush = 1; step(0, 0, -1);
        bus.flush = 0; set_m(3, 1, 2, 0, 0); step(1, -1, 0);

        // Reset mid-busy.
        set_m(0, 1, 2, 0, 1); step(1, -1, 0);
        set_m(3, 1, 2, 0, 0); step(0, -1, 1); step(0, -1, 1);
        rst = 1; step(0, 0, 1);
        rst = 0; step(1, -1, 0);

        // Randomized traffic, occasional reset.
        for (int i = 0; i < 4000; i++) begin
            rand_inputs();
            rst = ($urandom_range(0, 199) == 0);
            step(-1, -1, -1);
        end
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
